// File: rtl/fmul_result_collector.sv
// Tag tracker and writeback FIFO downstream of the non-stallable FP32 multiplier.
// Pairs issue tags with results LATENCY cycles later and gates issue with credits.
module fmul_result_collector #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int ROB_W   = 6,
    parameter int PREG_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ROB_W-1:0]  issue_rob_idx,
    input  logic [PREG_W-1:0] issue_rd,
    input  logic              issue_we,
    input  logic              flush,
    input  logic [31:0]       fmul_res,
    input  logic [4:0]        fmul_status,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_data,
    output logic [ROB_W-1:0]  wb_rob_idx,
    output logic [PREG_W-1:0] wb_rd,
    output logic              wb_we,
    output logic [4:0]        wb_fflags,
    output logic [4:0]        fflags_acc,
    input  logic              fflags_clr
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] tag_v_q, tag_v_d;
    logic [ROB_W-1:0]   tag_rob_q [LATENCY];
    logic [PREG_W-1:0]  tag_rd_q  [LATENCY];
    logic               tag_we_q  [LATENCY];

    logic [31:0]        mem_data_q  [DEPTH];
    logic [4:0]         mem_flags_q [DEPTH];
    logic [ROB_W-1:0]   mem_rob_q   [DEPTH];
    logic [PREG_W-1:0]  mem_rd_q    [DEPTH];
    logic               mem_we_q    [DEPTH];

    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [4:0]         fflags_acc_q;

    logic [OCC_W-1:0]   tag_cnt, occ;
    logic               issue_fire, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        tag_cnt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            tag_cnt = tag_cnt + OCC_W'(tag_v_q[i]);
        end
        occ = tag_cnt + OCC_W'(count_q);
    end

    assign issue_ready = (occ < OCC_W'(DEPTH)) & ~flush;
    assign issue_fire  = issue_valid & issue_ready;
    assign push        = tag_v_q[LATENCY-1];
    assign pop         = wb_valid & wb_ready;

    always_comb begin
        tag_v_d    = '0;
        tag_v_d[0] = issue_fire;
        for (int i = 1; i < LATENCY; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            fflags_acc_q <= '0;
        end else begin
            if (flush) begin
                tag_v_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                tag_v_q <= tag_v_d;
                if (push) tail_q <= ptr_inc(tail_q);
                if (pop)  head_q <= ptr_inc(head_q);
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
            // A retirement coinciding with a clear still contributes its flags.
            if (fflags_clr)
                fflags_acc_q <= pop ? wb_fflags : 5'd0;
            else if (pop)
                fflags_acc_q <= fflags_acc_q | wb_fflags;
        end
    end

    // Payload storage carries no reset; validity lives in tag_v_q and count_q.
    always_ff @(posedge clk) begin
        tag_rob_q[0] <= issue_rob_idx;
        tag_rd_q[0]  <= issue_rd;
        tag_we_q[0]  <= issue_we;
        for (int i = 1; i < LATENCY; i++) begin
            tag_rob_q[i] <= tag_rob_q[i-1];
            tag_rd_q[i]  <= tag_rd_q[i-1];
            tag_we_q[i]  <= tag_we_q[i-1];
        end
        if (push) begin
            mem_data_q[tail_q]  <= fmul_res;
            mem_flags_q[tail_q] <= fmul_status;
            mem_rob_q[tail_q]   <= tag_rob_q[LATENCY-1];
            mem_rd_q[tail_q]    <= tag_rd_q[LATENCY-1];
            mem_we_q[tail_q]    <= tag_we_q[LATENCY-1];
        end
    end

    assign wb_valid   = (count_q != '0);
    assign wb_data    = wb_valid ? mem_data_q[head_q]  : '0;
    assign wb_fflags  = wb_valid ? mem_flags_q[head_q] : '0;
    assign wb_rob_idx = wb_valid ? mem_rob_q[head_q]   : '0;
    assign wb_rd      = wb_valid ? mem_rd_q[head_q]    : '0;
    assign wb_we      = wb_valid ? mem_we_q[head_q]    : 1'b0;
    assign fflags_acc = fflags_acc_q;

endmodule

// File: tb/tb_fmul_result_collector.sv
// Randomized bench for fmul_result_collector against a timestamp/queue reference model.
module tb_fmul_result_collector;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;

    logic        clk = 0;
    logic        rst = 0;
    logic        issue_valid = 0, issue_we = 0, flush = 0, wb_ready = 0, fflags_clr = 0;
    logic [5:0]  issue_rob_idx = 0, issue_rd = 0;
    logic [31:0] fmul_res = 0;
    logic [4:0]  fmul_status = 0;
    logic        issue_ready, wb_valid, wb_we;
    logic [31:0] wb_data;
    logic [5:0]  wb_rob_idx, wb_rd;
    logic [4:0]  wb_fflags, fflags_acc;

    fmul_result_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH), .ROB_W(6), .PREG_W(6)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rob_idx(issue_rob_idx), .issue_rd(issue_rd), .issue_we(issue_we),
        .flush(flush), .fmul_res(fmul_res), .fmul_status(fmul_status),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rob_idx(wb_rob_idx), .wb_rd(wb_rd), .wb_we(wb_we),
        .wb_fflags(wb_fflags), .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    typedef struct { int t; logic [5:0] rob; logic [5:0] rd; logic we; } flight_t;
    typedef struct { logic [31:0] data; logic [4:0] fl; logic [5:0] rob; logic [5:0] rd; logic we; } res_t;

    flight_t     inflight[$];
    res_t        fifo[$];
    logic [4:0]  acc_m = 0;
    int          cyc = 0;
    int          n_checks = 0, n_err = 0;
    bit          ovr_en  [64];
    logic [31:0] ovr_res [64];
    logic [4:0]  ovr_st  [64];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit iv, input int rob, input int rd, input bit we,
                        input bit wr, input bit fl, input bit clr, output bit fired);
        bit samp, e_val, e_rdy, pop;
        res_t r;
        flight_t f;
        @(negedge clk);
        samp = (inflight.size() > 0) && (inflight[0].t == cyc - LATENCY);
        fmul_res    = $urandom;
        fmul_status = 5'($urandom_range(0, 31));
        if (samp && ovr_en[inflight[0].rob]) begin
            fmul_res    = ovr_res[inflight[0].rob];
            fmul_status = ovr_st[inflight[0].rob];
            ovr_en[inflight[0].rob] = 0;
        end
        issue_valid = iv; issue_rob_idx = 6'(rob); issue_rd = 6'(rd); issue_we = we;
        wb_ready = wr; flush = fl; fflags_clr = clr;
        #1;
        e_val = fifo.size() != 0;
        e_rdy = (inflight.size() + fifo.size() < DEPTH) && !fl;
        check_eq("wb_valid", wb_valid, e_val);
        check_eq("issue_ready", issue_ready, e_rdy);
        check_eq("wb_data", wb_data, e_val ? fifo[0].data : 32'd0);
        check_eq("wb_rob_idx", wb_rob_idx, e_val ? fifo[0].rob : 6'd0);
        check_eq("wb_rd", wb_rd, e_val ? fifo[0].rd : 6'd0);
        check_eq("wb_we", wb_we, e_val ? fifo[0].we : 1'b0);
        check_eq("wb_fflags", wb_fflags, e_val ? fifo[0].fl : 5'd0);
        check_eq("fflags_acc", fflags_acc, acc_m);
        fired = iv && e_rdy;
        pop   = wr && e_val;
        if (clr)      acc_m = pop ? fifo[0].fl : 5'd0;
        else if (pop) acc_m = acc_m | fifo[0].fl;
        if (pop) void'(fifo.pop_front());
        if (fl) begin
            inflight.delete();
            fifo.delete();
        end else begin
            if (samp) begin
                r.data = fmul_res; r.fl = fmul_status;
                r.rob = inflight[0].rob; r.rd = inflight[0].rd; r.we = inflight[0].we;
                fifo.push_back(r);
                void'(inflight.pop_front());
            end
            if (fired) begin
                f.t = cyc; f.rob = 6'(rob); f.rd = 6'(rd); f.we = we;
                inflight.push_back(f);
            end
        end
        cyc++;
    endtask

    task automatic idle(input bit wr, input int n);
        bit fd;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, wr, 0, 0, fd);
    endtask

    task automatic set_ovr(input int rob, input logic [31:0] res, input logic [4:0] st);
        ovr_en[rob] = 1; ovr_res[rob] = res; ovr_st[rob] = st;
    endtask

    initial begin : main
        bit fd;
        int rob_n;
        for (int i = 0; i < 64; i++) ovr_en[i] = 0;
        #3;
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_issue_ready", issue_ready, 1);
        check_eq("rst_fflags_acc", fflags_acc, 0);
        check_eq("rst_wb_fflags", wb_fflags, 0);
        #9 rst = 1;

        // Single op: latency 3 to wb_valid
        set_ovr(5, 32'h4080_0000, 5'd0);
        step(1, 5, 12, 1, 0, 0, 0, fd);
        idle(0, 2);
        check_eq("single_not_yet", wb_valid, 0);
        idle(0, 1);
        check_eq("single_valid", wb_valid, 1);
        check_eq("single_data", wb_data, 32'h4080_0000);
        check_eq("single_rob", wb_rob_idx, 5);
        check_eq("single_rd", wb_rd, 12);
        idle(1, 2);

        // Backpressure: four accepted, fifth held until a credit frees
        rob_n = 1;
        for (int i = 0; i < 8; i++) begin
            step(rob_n <= 5, rob_n, rob_n + 20, 1, 0, 0, 0, fd);
            if (fd) rob_n++;
        end
        check_eq("bp_issue_ready_low", issue_ready, 0);
        for (int i = 0; i < 20 && rob_n <= 5; i++) begin
            step(1, rob_n, rob_n + 20, 1, 1, 0, 0, fd);
            if (fd) rob_n++;
        end
        check_eq("bp_rob5_accepted", rob_n, 6);
        idle(1, 6);

        // Sticky flags with clear interactions
        set_ovr(10, 32'h7f80_0000, 5'h05);
        set_ovr(11, 32'h3f80_0000, 5'h10);
        set_ovr(12, 32'h4000_0000, 5'h01);
        step(1, 10, 1, 1, 0, 0, 1, fd);
        step(1, 11, 2, 1, 0, 0, 0, fd);
        step(1, 12, 3, 0, 0, 0, 0, fd);
        idle(0, 3);
        step(0, 0, 0, 0, 1, 0, 0, fd);
        step(0, 0, 0, 0, 1, 0, 0, fd);
        check_eq("flags_05", fflags_acc, 5'h05);
        step(0, 0, 0, 0, 1, 0, 1, fd);
        check_eq("flags_15", fflags_acc, 5'h15);
        step(0, 0, 0, 0, 0, 0, 1, fd);
        check_eq("flags_clr_pop", fflags_acc, 5'h01);
        idle(0, 1);
        check_eq("flags_clr", fflags_acc, 5'h00);

        // Flush with two in flight and one queued
        step(1, 40, 1, 1, 0, 0, 0, fd);
        step(1, 41, 2, 1, 0, 0, 0, fd);
        step(1, 42, 3, 1, 0, 0, 0, fd);
        step(1, 43, 4, 1, 0, 1, 0, fd);
        idle(1, 1);
        check_eq("flush_wb_valid", wb_valid, 0);
        check_eq("flush_issue_ready", issue_ready, 1);
        idle(1, 4);

        // Async reset with three queued
        set_ovr(50, 32'h1234_5678, 5'h08);
        for (int i = 0; i < 4; i++) step(1, 50 + i, i, 1, 0, 0, 0, fd);
        idle(0, 3);
        step(0, 0, 0, 0, 1, 0, 0, fd);
        idle(0, 1);
        @(posedge clk);
        #2 rst = 0;
        #1;
        check_eq("arst_wb_valid", wb_valid, 0);
        check_eq("arst_fflags_acc", fflags_acc, 0);
        check_eq("arst_issue_ready", issue_ready, 1);
        inflight.delete(); fifo.delete(); acc_m = 0;
        #1 rst = 1;
        step(1, 33, 7, 1, 0, 0, 0, fd);
        idle(0, 2);
        check_eq("arst_lat_early", wb_valid, 0);
        idle(0, 1);
        check_eq("arst_lat_valid", wb_valid, 1);
        check_eq("arst_lat_rob", wb_rob_idx, 33);
        idle(1, 2);

        // Streaming
        for (int i = 0; i < 100; i++) begin
            step(1, $urandom_range(0, 63), $urandom_range(0, 63), 1'($urandom), 1, 0, 0, fd);
            if (!fd) check_eq("stream_accept", 0, 1);
        end
        idle(1, 4);

        // Random mix
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 63), $urandom_range(0, 63),
                 1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 14) == 0, fd);
        idle(1, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
